// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-master arbiter for the single synchronous data-memory port.
//            Master 0 (CPU data stage) has priority over master 1 (DMA/debug).
//            Grants are combinational. Read data from the 1-cycle-latency
//            memory is routed back to the owning master one cycle after the
//            grant.
// Option   : `DMEM_ARB_STARVE_EN enables a starvation counter. When m1 has
//            been denied for STARVE_MAX consecutive cycles, the counter forces
//            an m1 grant. When the macro is undefined, the arbiter uses strict
//            m0 priority and STARVE_MAX has no effect.
// Ports    : clk, rst_n                - clock, async active-low reset
//            mN_req/we/a/wd/wmask      - master N request and payload
//            mN_gnt                    - master N accepted this cycle (comb)
//            mN_rvalid/mN_rd           - master N read return (registered)
//            mem_en/we/a/wd/wmask      - memory port, driven by the winner
//            mem_rd                    - memory read data (cycle after read)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MEM_ADDR_BUS
`define MEM_ADDR_BUS 31:0
`endif
`ifndef MEM_DATA_BUS
`define MEM_DATA_BUS 31:0
`endif
`ifndef MEM_WMASK_BUS
`define MEM_WMASK_BUS 3:0
`endif

module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [`MEM_ADDR_BUS]   m0_a,
    input  logic [`MEM_DATA_BUS]   m0_wd,
    input  logic [`MEM_WMASK_BUS]  m0_wmask,
    output logic                   m0_gnt,
    output logic                   m0_rvalid,
    output logic [`MEM_DATA_BUS]   m0_rd,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [`MEM_ADDR_BUS]   m1_a,
    input  logic [`MEM_DATA_BUS]   m1_wd,
    input  logic [`MEM_WMASK_BUS]  m1_wmask,
    output logic                   m1_gnt,
    output logic                   m1_rvalid,
    output logic [`MEM_DATA_BUS]   m1_rd,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [`MEM_ADDR_BUS]   mem_a,
    output logic [`MEM_DATA_BUS]   mem_wd,
    output logic [`MEM_WMASK_BUS]  mem_wmask,
    input  logic [`MEM_DATA_BUS]   mem_rd
);

    logic w_force_m1;   // starvation limit reached: m1 overrides m0
    logic w_m0_win;
    logic w_m1_win;
    logic resp_vld_q, resp_vld_d;
    logic resp_own_q, resp_own_d;  // 0 = m0, 1 = m1

    // Only the values 1..15 fit the 4-bit counter. This block is empty and
    // only serves as a hook to flag an out-of-range STARVE_MAX.
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_out_of_range
    end

    // While rst_n is low, no grant is issued. This keeps the memory quiet
    // during reset, even if the requesters keep their requests asserted.
    assign w_m1_win = rst_n & m1_req & (w_force_m1 | ~m0_req);
    assign w_m0_win = rst_n & m0_req & ~w_m1_win;

    assign m0_gnt = w_m0_win;
    assign m1_gnt = w_m1_win;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign w_force_m1 = (starve_cnt_q == c_STARVE_MAX);

    // The count only advances while m1 is waiting. A grant or a dropped
    // request resets it, so each forced grant gives m0 the next slot back.
    always_comb begin
        starve_cnt_d = 4'd0;
        if (m1_req && !w_m1_win) begin
            starve_cnt_d = w_force_m1 ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign w_force_m1 = 1'b0;
`endif

    // Memory port mux. When no master wins, every field is zeroed so that
    // an idle bus has no stale address or data on it.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        mem_wmask = '0;
        if (w_m1_win) begin
            mem_en    = 1'b1;
            mem_we    = m1_we;
            mem_a     = m1_a;
            mem_wd    = m1_wd;
            mem_wmask = m1_wmask;
        end else if (w_m0_win) begin
            mem_en    = 1'b1;
            mem_we    = m0_we;
            mem_a     = m0_a;
            mem_wd    = m0_wd;
            mem_wmask = m0_wmask;
        end
    end

    // This register records who owns the data that mem_rd will carry next
    // cycle. A new grant can be issued in the same cycle that the previous
    // read's data returns.
    assign resp_vld_d = mem_en & ~mem_we;
    assign resp_own_d = w_m1_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vld_q <= 1'b0;
            resp_own_q <= 1'b0;
        end else begin
            resp_vld_q <= resp_vld_d;
            resp_own_q <= resp_own_d;
        end
    end

    assign m0_rvalid = resp_vld_q & ~resp_own_q;
    assign m1_rvalid = resp_vld_q &  resp_own_q;
    assign m0_rd     = m0_rvalid ? mem_rd : '0;
    assign m1_rd     = m1_rvalid ? mem_rd : '0;

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter sharing the single data-memory port between the CPU data-memory stage (master 0) and a DMA/debug requester (master 1). It sits between the requesters and the synchronous data memory, which has 1-cycle read latency. Each cycle it grants at most one request, drives the memory port from the winner, and routes the returning read data to the owner one cycle later. Master 0 has priority; a starvation counter bounds master 1's wait.

## Interface
- STARVE_MAX, 4: consecutive denied cycles of a pending m1 request before m1 is forced to win (range 1–15).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1  request valid; held stable with its payload until the matching gnt.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_a, m1_a  in  `MEM_ADDR_BUS`  byte address.
- m0_wd, m1_wd  in  `MEM_DATA_BUS`  write data.
- m0_wmask, m1_wmask  in  `MEM_WMASK_BUS`  byte-lane write mask.
- m0_gnt, m1_gnt  out  1  combinational; request accepted this cycle.
- m0_rvalid, m1_rvalid  out  1  registered; read data valid this cycle.
- m0_rd, m1_rd  out  `MEM_DATA_BUS`  read data; 0 when the matching rvalid is 0.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_a  out  `MEM_ADDR_BUS`  memory address.
- mem_wd  out  `MEM_DATA_BUS`  memory write data.
- mem_wmask  out  `MEM_WMASK_BUS`  memory write mask.
- mem_rd  in  `MEM_DATA_BUS`  memory read data, valid the cycle after a read access.

## Operation
- Winner per cycle: m1 if m1_req and (starve_cnt == STARVE_MAX or !m0_req); else m0 if m0_req; else none.
- The winner's gnt = 1 and its we/a/wd/wmask drive the memory port. mem_en = 1. mem_we = winner.we.
- With no winner: mem_en = mem_we = 0. mem_a, mem_wd and mem_wmask are 0.
- The loser's gnt = 0. It holds its request.
- starve_cnt (4 bit) tracks m1's wait:
  - Increments (saturating at STARVE_MAX) each cycle m1_req = 1 and m1_gnt = 0.
  - Clears to 0 on m1_gnt or when m1_req = 0.
- Response register: on a granted read, resp_vld <= 1 and resp_own <= winner. Otherwise resp_vld <= 0.
- Read routing: mN_rvalid = resp_vld & (resp_own == N). mN_rd = mN_rvalid ? mem_rd : 0.
- Writes produce no rvalid. The write completes in the grant cycle.
- Outputs are not gated by the response cycle, so accesses can be issued back-to-back. A read in cycle N and any access in N+1 are both legal.

## Timing
- Grant latency: 0 cycles (same-cycle combinational gnt).
- Read data returns 1 cycle after the grant (rvalid in N+1).
- Reset (rst_n = 0, asynchronous) clears:
  - resp_vld = 0, resp_own = 0, starve_cnt = 0.
  - All rvalid = 0 and all rd = 0.
  - All gnt = 0, mem_en = 0 and mem_we = 0, because gnt and mem_en/mem_we are forced to 0 while rst_n = 0.
- Reset asserted between a read grant and its return: the response is dropped and no rvalid fires after release.
- Simultaneous requests with starve_cnt < STARVE_MAX: m0 wins. With starve_cnt == STARVE_MAX: m1 wins, and starve_cnt clears next cycle.
- Worst-case m1 wait under continuous m0 traffic: STARVE_MAX denied cycles, then a grant.
- m0 wait under continuous m1 traffic: 1 cycle, because starve_cnt clears after each forced m1 grant.
- A request dropped before grant is ignored. No state is retained except starve_cnt, which clears.

## Configuration
- DMEM_ARB_STARVE_EN defined: starvation counter and forced m1 grant are active, as described above.
- DMEM_ARB_STARVE_EN undefined:
  - Strict priority; m1 wins only when m0_req = 0.
  - starve_cnt is not instantiated and STARVE_MAX is ignored.
  - All other behaviour is identical.

## Test plan
- Read isolation: after reset, m0 reads a=0x100 with mem model holding 0xDEADBEEF.
  - Cycle 0: m0_gnt = 1, mem_a = 0x100, mem_we = 0.
  - Cycle 1: m0_rvalid = 1, m0_rd = 0xDEADBEEF, m1_rvalid = 0.
- Write passthrough: m1 writes a=0x204, wd=0x12345678, wmask=4'b0011 with m0 idle.
  - m1_gnt = 1, mem_we = 1, mem_wmask = 4'b0011.
  - No rvalid next cycle.
- Starvation (macro on, STARVE_MAX = 4): m0 and m1 read continuously.
  - m0 is granted cycles 0–3 and m1 in cycle 4.
  - m0 is granted again in cycle 5.
  - Macro off: m1 is never granted.
- Back-to-back routing: m0 reads 0x10 in cycle 0, m1 reads 0x20 in cycle 1.
  - m0_rvalid in cycle 1 with mem[0x10].
  - m1_rvalid in cycle 2 with mem[0x20].
  - Never both rvalid at once.
- Reset mid-read: m0 read granted in cycle 0, rst_n pulsed low in cycle 0.5.
  - m0_rvalid = 0 from reset assertion onward.
  - m0_rvalid stays 0 after release.
  - mem_en = 0 while rst_n = 0.
- Idle: no requests for 10 cycles.
  - mem_en = 0, mem_a = 0, all gnt and rvalid 0, starve_cnt stays 0.
